// File: rtl/cam_stream_gen.sv
// OV7670-style RGB565 stream source: emits vsync/href/px_data frames from an
// internal test-pattern generator, two bytes per pixel, high byte first.
module cam_stream_gen #(
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 120,
    parameter int VS_PULSE = 8,
    parameter int V_FRONT  = 16,
    parameter int H_BLANK  = 16,
    parameter int V_BACK   = 16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    input  logic [15:0] solid_color,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  px_data,
    output logic        frame_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int BLANK_MAX = max2(max2(VS_PULSE, V_FRONT), max2(H_BLANK, V_BACK));
    localparam int CNT_W     = $clog2(BLANK_MAX) + 1;
    // x/y carry at least the bits the gradient and checker patterns read
    localparam int X_W       = max2($clog2(H_ACTIVE) + 1, 6);
    localparam int Y_W       = max2($clog2(V_ACTIVE) + 1, 6);
    localparam int BAR_LEN   = H_ACTIVE / 8;
    localparam int BC_W      = $clog2(BAR_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VFRONT,
        S_LINE,
        S_HBLANK,
        S_VBACK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic                phase_q, phase_d;
    logic [BC_W-1:0]     bar_cnt_q, bar_cnt_d;
    logic [2:0]          bar_idx_q, bar_idx_d;
    logic [1:0]          pat_q, pat_d;
    logic [15:0]         solid_q, solid_d;

    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          px_q, px_d;
    logic                frame_done_q, frame_done_d;

    logic [15:0]         pix;
    logic                cnt_last;

    // State, counters and registered outputs; reset clears everything at once
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= 1'b0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            pat_q        <= '0;
            solid_q      <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            px_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            pat_q        <= pat_d;
            solid_q      <= solid_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            px_q         <= px_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Terminal count of the current blanking segment
    always_comb begin
        cnt_last = 1'b0;
        unique case (state_q)
            S_VSYNC:  cnt_last = (cnt_q == CNT_W'(VS_PULSE - 1));
            S_VFRONT: cnt_last = (cnt_q == CNT_W'(V_FRONT - 1));
            S_HBLANK: cnt_last = (cnt_q == CNT_W'(H_BLANK - 1));
            S_VBACK:  cnt_last = (cnt_q == CNT_W'(V_BACK - 1));
            default:  cnt_last = 1'b0;
        endcase
    end

    // Next-state and counter sequencing through the frame segments
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        phase_d   = phase_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        solid_d   = solid_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_VSYNC;
                    cnt_d   = '0;
                    y_d     = '0;
                    pat_d   = pattern;
                    solid_d = solid_color;
                end
            end
            S_VSYNC: begin
                if (cnt_last) begin
                    state_d = S_VFRONT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VFRONT: begin
                if (cnt_last) begin
                    state_d   = S_LINE;
                    cnt_d     = '0;
                    x_d       = '0;
                    phase_d   = 1'b0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LINE: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (x_q == X_W'(H_ACTIVE - 1)) begin
                        state_d = S_HBLANK;
                        cnt_d   = '0;
                        x_d     = '0;
                        y_d     = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                        // bar position tracked by a run counter instead of dividing x
                        if (bar_cnt_q == BC_W'(BAR_LEN - 1)) begin
                            bar_cnt_d = '0;
                            bar_idx_d = bar_idx_q + 1'b1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    // y already counts completed lines here
                    if (y_q < Y_W'(V_ACTIVE)) begin
                        state_d   = S_LINE;
                        x_d       = '0;
                        phase_d   = 1'b0;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                    end else begin
                        state_d = S_VBACK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VBACK: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = S_VSYNC;
                        y_d     = '0;
                        pat_d   = pattern;
                        solid_d = solid_color;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Test-pattern pixel for the position the next cycle will present
    always_comb begin
        pix = '0;
        unique case (pat_q)
            2'd0: pix = solid_q;
            2'd1: begin
                unique case (bar_idx_d)
                    3'd0: pix = 16'hFFFF;
                    3'd1: pix = 16'hFFE0;
                    3'd2: pix = 16'h07FF;
                    3'd3: pix = 16'h07E0;
                    3'd4: pix = 16'hF81F;
                    3'd5: pix = 16'hF800;
                    3'd6: pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd2: pix = {x_d[4:0], y_d[5:0], ~x_d[4:0]};
            default: pix = (x_d[3] ^ y_d[3]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    // Output values registered alongside the state they belong to
    always_comb begin
        vsync_d      = (state_d == S_VSYNC);
        href_d       = (state_d == S_LINE);
        px_d         = '0;
        if (href_d) begin
            px_d = phase_d ? pix[7:0] : pix[15:8];
        end
        frame_done_d = (state_q == S_HBLANK) && (state_d == S_VBACK);
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign px_data    = px_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen: two small-geometry instances checked every cycle
// against a frame-position model, plus directed literal checks.
module tb_cam_stream_gen;

    // instance 1 geometry (timing / bars / solid)
    localparam int HA1 = 8,  VA1 = 2,  VS1 = 2, VF1 = 3, HB1 = 4, VB1 = 5;
    localparam int P1  = VS1 + VF1 + VA1 * (2 * HA1 + HB1) + VB1;
    // instance 2 geometry (checkerboard needs x and y beyond 8)
    localparam int HA2 = 32, VA2 = 10, VS2 = 2, VF2 = 3, HB2 = 4, VB2 = 5;
    localparam int P2  = VS2 + VF2 + VA2 * (2 * HA2 + HB2) + VB2;

    logic        pclk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern;
    logic [15:0] solid_color;

    logic        vsync1, href1, fd1;
    logic [7:0]  px1;
    logic        vsync2, href2, fd2;
    logic [7:0]  px2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    cam_stream_gen #(
        .H_ACTIVE(HA1), .V_ACTIVE(VA1), .VS_PULSE(VS1),
        .V_FRONT(VF1), .H_BLANK(HB1), .V_BACK(VB1)
    ) dut (
        .pclk(pclk), .rst(rst), .enable(enable), .pattern(pattern),
        .solid_color(solid_color), .vsync(vsync1), .href(href1),
        .px_data(px1), .frame_done(fd1)
    );

    cam_stream_gen #(
        .H_ACTIVE(HA2), .V_ACTIVE(VA2), .VS_PULSE(VS2),
        .V_FRONT(VF2), .H_BLANK(HB2), .V_BACK(VB2)
    ) dut2 (
        .pclk(pclk), .rst(rst), .enable(enable), .pattern(pattern),
        .solid_color(solid_color), .vsync(vsync2), .href(href2),
        .px_data(px2), .frame_done(fd2)
    );

    // ---------------- model ----------------
    function automatic logic [15:0] model_pixel(input int ha, input int x, input int y,
                                                 input logic [1:0] pat, input logic [15:0] col);
        int r, g, b;
        case (pat)
            2'd0: return col;
            2'd1: begin
                case (x / (ha / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd2: begin
                r = x % 32;
                g = y % 64;
                b = 31 - (x % 32);
                return 16'(r * 2048 + g * 32 + b);
            end
            default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // expected {vsync, href, frame_done, px} at cycle t of a frame (t<0: idle)
    function automatic logic [10:0] model_out(input int ha, input int va, input int vs,
                                              input int vf, input int hb, input int t,
                                              input logic [1:0] pat, input logic [15:0] col);
        int lp, t3, off;
        logic [15:0] p;
        lp = 2 * ha + hb;
        if (t < 0) return '0;
        if (t < vs) return 11'b100_0000_0000;
        if (t < vs + vf) return '0;
        t3 = t - vs - vf;
        if (t3 < va * lp) begin
            off = t3 % lp;
            if (off >= 2 * ha) return '0;
            p = model_pixel(ha, off / 2, t3 / lp, pat, col);
            return {3'b010, (off % 2 == 0) ? p[15:8] : p[7:0]};
        end
        if (t3 == va * lp) return 11'b001_0000_0000;
        return '0;
    endfunction

    int          t1 = -1, t2 = -1;
    logic [1:0]  pat1, pat2;
    logic [15:0] col1, col2;

    // frame position of each instance, advanced by the frame-level rules
    always @(posedge pclk or posedge rst) begin
        if (rst) begin
            t1 <= -1;
            t2 <= -1;
        end else begin
            if (t1 < 0 || t1 == P1 - 1) begin
                if (enable) begin
                    t1 <= 0; pat1 <= pattern; col1 <= solid_color;
                end else begin
                    t1 <= -1;
                end
            end else begin
                t1 <= t1 + 1;
            end
            if (t2 < 0 || t2 == P2 - 1) begin
                if (enable) begin
                    t2 <= 0; pat2 <= pattern; col2 <= solid_color;
                end else begin
                    t2 <= -1;
                end
            end else begin
                t2 <= t2 + 1;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge pclk) begin
        logic [10:0] e, g;
        e = model_out(HA1, VA1, VS1, VF1, HB1, t1, pat1, col1);
        g = {vsync1, href1, fd1, px1};
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL model_dut1 t=%0d: got vs/hr/fd/px=%b/%b/%b/%02h want %b/%b/%b/%02h",
                     t1, g[10], g[9], g[8], g[7:0], e[10], e[9], e[8], e[7:0]);
        end
        e = model_out(HA2, VA2, VS2, VF2, HB2, t2, pat2, col2);
        g = {vsync2, href2, fd2, px2};
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL model_dut2 t=%0d: got vs/hr/fd/px=%b/%b/%b/%02h want %b/%b/%b/%02h",
                     t2, g[10], g[9], g[8], g[7:0], e[10], e[9], e[8], e[7:0]);
        end
    end

    // capture-side view: every href burst must be a whole line
    int run1 = 0;
    always @(negedge pclk) begin
        if (rst) begin
            run1 = 0;
        end else if (href1) begin
            run1++;
        end else if (run1 != 0) begin
            vectors++;
            if (run1 != 2 * HA1) begin
                miscompares++;
                $display("FAIL line_len: got %0d bytes want %0d", run1, 2 * HA1);
            end
            run1 = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic sig(input int code);
        case (code)
            0: return vsync1;
            1: return href1;
            2: return fd1;
            3: return vsync2;
            default: return href2;
        endcase
    endfunction

    task automatic wait_rise(input int code, input int limit, input string name);
        logic prev;
        bit   ok;
        prev = sig(code);
        ok   = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge pclk);
            if (sig(code) && !prev) ok = 1'b1;
            prev = sig(code);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got no rising edge in %0d cycles want one", name, limit);
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [7:0] bars_exp [16];
    int vs_first, vs_cnt, hr_first, hr_cnt, fd_cyc, hr25, vs50, sol_idx, rises;
    bit fd_seen;
    int quiet;

    initial begin
        bars_exp = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                     8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        rst = 1'b1;
        enable = 1'b0;
        pattern = 2'd0;
        solid_color = 16'hF81F;
        repeat (3) @(negedge pclk);
        check("reset_state", {vsync1, href1, fd1, px1}, 0);

        // T1/T2: frame timing from release, solid colour bytes
        rst = 1'b0;
        enable = 1'b1;
        vs_first = -1; vs_cnt = 0; hr_first = -1; hr_cnt = 0; fd_cyc = -1; sol_idx = 0;
        hr25 = 0; vs50 = 0;
        for (int c = 0; c <= 50; c++) begin
            @(negedge pclk);
            if (vsync1 && vs_first < 0) vs_first = c;
            if (vsync1 && c < 50) vs_cnt++;
            if (href1 && hr_first < 0) hr_first = c;
            if (href1 && c < 50) hr_cnt++;
            if (fd1 && fd_cyc < 0) fd_cyc = c;
            if (c == 25) hr25 = int'(href1);
            if (c == 50) vs50 = int'(vsync1);
            if (href1 && sol_idx < 16) begin
                check($sformatf("solid_b%0d", sol_idx), px1, (sol_idx % 2 == 0) ? 8'hF8 : 8'h1F);
                sol_idx++;
            end
        end
        check("vsync_first_cycle", vs_first, 0);
        check("vsync_width", vs_cnt, 2);
        check("href_first_cycle", hr_first, 5);
        check("href_cycles_frame", hr_cnt, 32);
        check("href_line1_cycle25", hr25, 1);
        check("frame_done_cycle", fd_cyc, 45);
        check("next_vsync_cycle50", vs50, 1);

        // T3: colour bars on the next instance-1 frame
        pattern = 2'd1;
        wait_rise(0, 100, "bars_vsync");
        wait_rise(1, 20, "bars_href");
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge pclk);
            check($sformatf("bars_b%0d", i), px1, bars_exp[i]);
        end

        // T4: checkerboard on instance 2, lines 0 and 8
        pattern = 2'd3;
        wait_rise(3, 1000, "chk_vsync");
        wait_rise(4, 20, "chk_href0");
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge pclk);
            check($sformatf("chk_l0_b%0d", i), px2, ((i / 2) >= 8) ? 8'hFF : 8'h00);
        end
        for (int k = 0; k < 8; k++) wait_rise(4, 100, "chk_href");
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge pclk);
            check($sformatf("chk_l8_b%0d", i), px2, ((i / 2) >= 8) ? 8'h00 : 8'hFF);
        end

        // T5: drop enable during line 0 of an instance-1 frame
        pattern = 2'd2;
        wait_rise(0, 100, "stop_vsync");
        wait_rise(1, 20, "stop_href");
        repeat (3) @(negedge pclk);
        enable = 1'b0;
        rises = 0;
        fd_seen = 1'b0;
        for (int i = 0; i < 100 && !fd_seen; i++) begin
            logic prev_h;
            prev_h = href1;
            @(negedge pclk);
            if (href1 && !prev_h) rises++;
            if (fd1) fd_seen = 1'b1;
        end
        check("stop_frame_done", int'(fd_seen), 1);
        check("stop_remaining_lines", rises, 1);
        quiet = 0;
        repeat (30) begin
            @(negedge pclk);
            if (vsync1 || href1 || fd1) quiet++;
        end
        check("stop_idle_activity", quiet, 0);
        enable = 1'b1;
        @(negedge pclk);
        check("restart_vsync", vsync1, 1);

        // T6: asynchronous reset in the middle of a line
        wait_rise(1, 100, "rst_href");
        repeat (4) @(negedge pclk);
        @(posedge pclk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_dut1", {vsync1, href1, fd1, px1}, 0);
        check("rst_async_dut2", {vsync2, href2, fd2, px2}, 0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        check("post_rst_vsync", vsync1, 1);
        repeat (150) @(negedge pclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
